dmem_arbiter: RTL

Two-port arbiter and access sequencer for the shared data memory. Port 0 serves the pipeline MEM stage; port 1 serves the debug/program loader. The block arbitrates between them, drives one word access per grant onto the data-memory port (`writeEn`, `readEn`, `address`, `dataIn`), and captures `dataOut` into a registered response. It sits between the MEM stage / loader and `dataMem`.

---
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter and access sequencer (round-robin option: DMEM_ARB_RR_EN)
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,

   output logic              mem_writeEn,
   output logic              mem_readEn,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut,

   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;

   // Latched command of the current winner
   logic                win;
   logic                cmd_we;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;

   logic                any_req;
   logic                pick;
   logic                latch;
   logic                misaligned;

   assign any_req    = m0_req | m1_req;
   assign misaligned = |cmd_addr[1:0];
   assign busy       = (state != S_IDLE);

`ifdef DMEM_ARB_RR_EN
   // Port served most recently; reset to port 1 so the first tie goes to port 0
   logic last;

   // Round-robin choice: on a tie the port not served last wins
   always_comb begin
      pick = 1'b0;
      if (m0_req && m1_req) begin
         pick = ~last;
      end else if (m1_req) begin
         pick = 1'b1;
      end
   end

   // Pointer moves on every entry into ACCESS
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (latch) begin
         last <= pick;
      end
   end
`else
   // Fixed priority: port 0 wins whenever it requests
   always_comb begin
      pick = ~m0_req;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, command latch enable and all strobes/pulses
   always_comb begin
      state_nx    = state;
      latch       = 1'b0;
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      m0_rvalid   = 1'b0;
      m1_rvalid   = 1'b0;
      m0_err      = 1'b0;
      m1_err      = 1'b0;
      mem_writeEn = 1'b0;
      mem_readEn  = 1'b0;
      mem_address = '0;
      mem_dataIn  = '0;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               latch    = 1'b1;
               state_nx = S_ACCESS;
            end
         end
         S_ACCESS: begin
            m0_gnt   = ~win;
            m1_gnt   = win;
            if (!misaligned) begin
               mem_writeEn = cmd_we;
               mem_readEn  = ~cmd_we;
               mem_address = cmd_addr;
               if (cmd_we) begin
                  mem_dataIn = cmd_wdata;
               end
            end
            state_nx = S_DONE;
         end
         S_DONE: begin
            m0_rvalid = ~win;
            m1_rvalid = win;
            m0_err    = ~win & misaligned;
            m1_err    = win & misaligned;
            // A request still high here is a fresh command
            if (any_req) begin
               latch    = 1'b1;
               state_nx = S_ACCESS;
            end else begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Capture the winner's command at arbitration
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win       <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (latch) begin
         win       <= pick;
         cmd_we    <= pick ? m1_we    : m0_we;
         cmd_addr  <= pick ? m1_addr  : m0_addr;
         cmd_wdata <= pick ? m1_wdata : m0_wdata;
      end
   end

   // Read data: loaded at the close of ACCESS for reads, cleared on misalignment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (state == S_ACCESS) begin
         if (misaligned) begin
            if (win) begin
               m1_rdata <= '0;
            end else begin
               m0_rdata <= '0;
            end
         end else if (!cmd_we) begin
            if (win) begin
               m1_rdata <= mem_dataOut;
            end else begin
               m0_rdata <= mem_dataOut;
            end
         end
      end
   end

endmodule
